// File: rtl/conv_mem_arbiter.sv
// Shares one data-memory request port between the core LSU and the convolution load engine.
// Accelerator reads are buffered in a FIFO and responses are steered back through an owner FIFO.
module conv_mem_arbiter #(
  parameter int CONV_FIFO_DEPTH = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_rd_i,
  input  logic [3:0]  core_wr_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_wr_i,
  output logic        core_accept_o,
  output logic        core_ack_o,
  output logic [31:0] core_data_rd_o,
  input  logic        conv_rd_i,
  input  logic [31:0] conv_addr_i,
  output logic        conv_ack_o,
  output logic [31:0] conv_data_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_wr_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_rd_i,
  output logic        conv_ovf_o,
  output logic        ack_err_o
);

  localparam int CAW = $clog2(CONV_FIFO_DEPTH);
  localparam int CCW = $clog2(CONV_FIFO_DEPTH + 1);
  localparam int RAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int RCW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CCW-1:0] CONV_FULL  = CCW'(CONV_FIFO_DEPTH);
  localparam logic [RCW-1:0] ROUTE_FULL = RCW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, HOLD_CORE, HOLD_CONV} state_t;

  state_t          state_q;
  logic            last_conv_q;
  logic            conv_ovf_q;
  logic            ack_err_q;

  logic [31:0]     conv_mem [CONV_FIFO_DEPTH];
  logic [CAW-1:0]  conv_wp_q, conv_rp_q;
  logic [CCW-1:0]  conv_cnt_q;
  logic            route_mem [MAX_OUTSTANDING];
  logic [RAW-1:0]  route_wp_q, route_rp_q;
  logic [RCW-1:0]  route_cnt_q;

  logic core_pend, conv_pend, conv_full, route_empty, route_full;
  logic grant_valid, sel_conv, accept;
  logic conv_push, conv_pop, conv_drop, route_push, route_pop, route_owner;

  function automatic logic [CAW-1:0] conv_next(input logic [CAW-1:0] p);
    return (p == CAW'(CONV_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RAW-1:0] route_next(input logic [RAW-1:0] p);
    return (p == RAW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    core_pend   = core_rd_i | (|core_wr_i);
    conv_pend   = (conv_cnt_q != '0);
    conv_full   = (conv_cnt_q == CONV_FULL);
    route_empty = (route_cnt_q == '0);
    route_full  = (route_cnt_q == ROUTE_FULL);
    grant_valid = 1'b0;
    sel_conv    = 1'b0;
    unique case (state_q)
      HOLD_CORE: grant_valid = 1'b1;
      HOLD_CONV: begin
        grant_valid = 1'b1;
        sel_conv    = 1'b1;
      end
      default: begin
        // On a tie the source served last loses.
        grant_valid = !route_full && (core_pend || conv_pend);
        sel_conv    = conv_pend && (!core_pend || !last_conv_q);
      end
    endcase
  end

  assign accept      = grant_valid & mem_accept_i;
  assign conv_pop    = accept & sel_conv;
  assign conv_push   = conv_rd_i & (!conv_full | conv_pop);
  assign conv_drop   = conv_rd_i & conv_full & !conv_pop;
  assign route_push  = accept;
  assign route_pop   = mem_ack_i & !route_empty;
  assign route_owner = route_mem[route_rp_q];

  assign mem_rd_o      = grant_valid & (sel_conv | core_rd_i);
  assign mem_wr_o      = (grant_valid && !sel_conv) ? core_wr_i : 4'b0;
  assign mem_addr_o    = !grant_valid ? 32'b0 : (sel_conv ? conv_mem[conv_rp_q] : core_addr_i);
  assign mem_data_wr_o = (grant_valid && !sel_conv) ? core_data_wr_i : 32'b0;

  assign core_accept_o  = accept & !sel_conv;
  assign core_ack_o     = route_pop & !route_owner;
  assign conv_ack_o     = route_pop & route_owner;
  assign core_data_rd_o = mem_data_rd_i;
  assign conv_data_o    = mem_data_rd_i;
  assign conv_ovf_o     = conv_ovf_q;
  assign ack_err_o      = ack_err_q;

  // NOTE: FIFO storage is not reset; the pointers and counts alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (conv_push)  conv_mem[conv_wp_q]   <= conv_addr_i;
    if (route_push) route_mem[route_wp_q] <= sel_conv;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_conv_q <= 1'b1;
      conv_ovf_q  <= 1'b0;
      ack_err_q   <= 1'b0;
      conv_wp_q   <= '0;
      conv_rp_q   <= '0;
      conv_cnt_q  <= '0;
      route_wp_q  <= '0;
      route_rp_q  <= '0;
      route_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (grant_valid && !mem_accept_i) state_q <= sel_conv ? HOLD_CONV : HOLD_CORE;
        default: if (mem_accept_i) state_q <= IDLE;
      endcase
      if (accept)    last_conv_q <= sel_conv;
      if (conv_drop) conv_ovf_q  <= 1'b1;
      if (mem_ack_i && route_empty) ack_err_q <= 1'b1;

      if (conv_push) conv_wp_q <= conv_next(conv_wp_q);
      if (conv_pop)  conv_rp_q <= conv_next(conv_rp_q);
      conv_cnt_q <= conv_cnt_q + CCW'(conv_push) - CCW'(conv_pop);

      if (route_push) route_wp_q <= route_next(route_wp_q);
      if (route_pop)  route_rp_q <= route_next(route_rp_q);
      route_cnt_q <= route_cnt_q + RCW'(route_push) - RCW'(route_pop);
    end
  end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Self-checking bench for conv_mem_arbiter: directed vector table, corner sequences and
// randomized traffic compared against a queue-based model of the arbitration rules.
module tb_conv_mem_arbiter;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 4;

  logic        clk_i, rst_i;
  logic        core_rd_i;
  logic [3:0]  core_wr_i;
  logic [31:0] core_addr_i, core_data_wr_i;
  logic        core_accept_o, core_ack_o;
  logic [31:0] core_data_rd_o;
  logic        conv_rd_i;
  logic [31:0] conv_addr_i;
  logic        conv_ack_o;
  logic [31:0] conv_data_o;
  logic        mem_rd_o;
  logic [3:0]  mem_wr_o;
  logic [31:0] mem_addr_o, mem_data_wr_o;
  logic        mem_accept_i, mem_ack_i;
  logic [31:0] mem_data_rd_i;
  logic        conv_ovf_o, ack_err_o;

  conv_mem_arbiter #(.CONV_FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_rd_i(core_rd_i), .core_wr_i(core_wr_i), .core_addr_i(core_addr_i),
    .core_data_wr_i(core_data_wr_i), .core_accept_o(core_accept_o),
    .core_ack_o(core_ack_o), .core_data_rd_o(core_data_rd_o),
    .conv_rd_i(conv_rd_i), .conv_addr_i(conv_addr_i),
    .conv_ack_o(conv_ack_o), .conv_data_o(conv_data_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
    .mem_data_wr_o(mem_data_wr_o), .mem_accept_i(mem_accept_i),
    .mem_ack_i(mem_ack_i), .mem_data_rd_i(mem_data_rd_i),
    .conv_ovf_o(conv_ovf_o), .ack_err_o(ack_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        core_rd;
    logic [3:0]  core_wr;
    logic [31:0] core_addr;
    logic        conv_rd;
    logic [31:0] conv_addr;
    logic        acc;
    logic        ack;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_rd;
    logic [3:0]  e_wr;
    logic [31:0] e_addr;
    logic        e_cacc;
    logic        e_cack;
    logic        e_vack;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: FIFOs as queues, the pending grant as "which source is waiting".
  logic [31:0] mq_conv[$];
  bit          mq_route[$];
  int          m_held;
  bit          m_last_conv;
  bit          m_ovf, m_err;
  int          p_src;
  bit          p_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_conv.delete();
    mq_route.delete();
    m_held      = -1;
    m_last_conv = 1'b1;
    m_ovf       = 1'b0;
    m_err       = 1'b0;
  endtask

  task automatic drive(input stim_t s);
    core_rd_i      = s.core_rd;
    core_wr_i      = s.core_wr;
    core_addr_i    = s.core_addr;
    core_data_wr_i = 32'h1234_5678;
    conv_rd_i      = s.conv_rd;
    conv_addr_i    = s.conv_addr;
    mem_accept_i   = s.acc;
    mem_ack_i      = s.ack;
    mem_data_rd_i  = s.rdata;
  endtask

  task automatic predict_and_check();
    bit          cp, vp;
    logic        e_rd;
    logic [3:0]  e_wr;
    logic [31:0] e_addr, e_wd;
    bit          e_cack, e_vack;
    cp = core_rd_i || (core_wr_i != 4'b0);
    vp = mq_conv.size() > 0;
    if (m_held >= 0)                  p_src = m_held;
    else if (mq_route.size() >= MAX_OUT) p_src = -1;
    else if (cp && vp)                p_src = m_last_conv ? 0 : 1;
    else if (cp)                      p_src = 0;
    else if (vp)                      p_src = 1;
    else                              p_src = -1;
    e_rd   = (p_src == 1) ? 1'b1 : ((p_src == 0) ? core_rd_i : 1'b0);
    e_wr   = (p_src == 0) ? core_wr_i : 4'b0;
    e_addr = (p_src == 1) ? mq_conv[0] : ((p_src == 0) ? core_addr_i : 32'b0);
    e_wd   = (p_src == 0) ? core_data_wr_i : 32'b0;
    p_acc  = (p_src >= 0) && mem_accept_i;
    e_cack = mem_ack_i && (mq_route.size() > 0) && !mq_route[0];
    e_vack = mem_ack_i && (mq_route.size() > 0) && mq_route[0];
    check("mem_rd", 32'(mem_rd_o), 32'(e_rd));
    check("mem_wr", 32'(mem_wr_o), 32'(e_wr));
    check("mem_addr", mem_addr_o, e_addr);
    check("mem_wdata", mem_data_wr_o, e_wd);
    check("core_accept", 32'(core_accept_o), 32'(p_acc && p_src == 0));
    check("core_ack", 32'(core_ack_o), 32'(e_cack));
    check("conv_ack", 32'(conv_ack_o), 32'(e_vack));
    check("core_rdata", core_data_rd_o, mem_data_rd_i);
    check("conv_rdata", conv_data_o, mem_data_rd_i);
    check("conv_ovf", 32'(conv_ovf_o), 32'(m_ovf));
    check("ack_err", 32'(ack_err_o), 32'(m_err));
  endtask

  task automatic model_update();
    if (mem_ack_i) begin
      if (mq_route.size() > 0) void'(mq_route.pop_front());
      else                     m_err = 1'b1;
    end
    if (p_acc) mq_route.push_back(p_src == 1);
    if (p_acc && p_src == 1) void'(mq_conv.pop_front());
    if (conv_rd_i) begin
      if (mq_conv.size() < DEPTH) mq_conv.push_back(conv_addr_i);
      else                        m_ovf = 1'b1;
    end
    m_held = (p_src >= 0 && !p_acc) ? p_src : -1;
    if (p_acc) m_last_conv = (p_src == 1);
  endtask

  function automatic stim_t mk_s(input logic crd, input logic [3:0] cwr, input logic [31:0] caddr,
                                 input logic vrd, input logic [31:0] vaddr, input logic acc,
                                 input logic ack, input logic [31:0] rdata);
    stim_t s;
    s.core_rd = crd; s.core_wr = cwr; s.core_addr = caddr;
    s.conv_rd = vrd; s.conv_addr = vaddr;
    s.acc = acc; s.ack = ack; s.rdata = rdata;
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input logic erd, input logic [3:0] ewr,
                              input logic [31:0] eaddr, input logic ecacc,
                              input logic ecack, input logic evack);
    vec_t v;
    v.s = s; v.e_rd = erd; v.e_wr = ewr; v.e_addr = eaddr;
    v.e_cacc = ecacc; v.e_cack = ecack; v.e_vack = evack;
    return v;
  endfunction

  task automatic step(input stim_t s);
    drive(s);
    #3;
    predict_and_check();
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  vec_t tbl[26];

  initial begin
    // Core read, conv burst, contention, stalled conv grant, then a core write.
    tbl[0]  = mk(mk_s(1, 0, 32'h100, 0, 0, 1, 0, 0),                       1, 0, 32'h100,  1, 0, 0);
    tbl[1]  = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF),                   0, 0, 32'h0,    0, 1, 0);
    tbl[2]  = mk(mk_s(0, 0, 0, 1, 32'h2000, 1, 0, 0),                       0, 0, 32'h0,    0, 0, 0);
    tbl[3]  = mk(mk_s(0, 0, 0, 1, 32'h2004, 1, 0, 0),                       1, 0, 32'h2000, 0, 0, 0);
    tbl[4]  = mk(mk_s(0, 0, 0, 1, 32'h2008, 1, 1, 32'hA0000000),            1, 0, 32'h2004, 0, 0, 1);
    tbl[5]  = mk(mk_s(0, 0, 0, 1, 32'h200C, 1, 1, 32'hA1111111),            1, 0, 32'h2008, 0, 0, 1);
    tbl[6]  = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hA2222222),                   1, 0, 32'h200C, 0, 0, 1);
    tbl[7]  = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hA3333333),                   0, 0, 32'h0,    0, 0, 1);
    tbl[8]  = mk(mk_s(0, 0, 0, 1, 32'h3000, 1, 0, 0),                       0, 0, 32'h0,    0, 0, 0);
    tbl[9]  = mk(mk_s(1, 0, 32'h400, 1, 32'h3004, 1, 0, 0),                 1, 0, 32'h400,  1, 0, 0);
    tbl[10] = mk(mk_s(1, 0, 32'h404, 1, 32'h3008, 1, 1, 32'hC0),            1, 0, 32'h3000, 0, 1, 0);
    tbl[11] = mk(mk_s(1, 0, 32'h404, 0, 0, 1, 1, 32'hC1),                   1, 0, 32'h404,  1, 0, 1);
    tbl[12] = mk(mk_s(1, 0, 32'h408, 0, 0, 1, 1, 32'hC2),                   1, 0, 32'h3004, 0, 1, 0);
    tbl[13] = mk(mk_s(1, 0, 32'h408, 0, 0, 1, 1, 32'hC3),                   1, 0, 32'h408,  1, 0, 1);
    tbl[14] = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hC4),                         1, 0, 32'h3008, 0, 1, 0);
    tbl[15] = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hC5),                         0, 0, 32'h0,    0, 0, 1);
    tbl[16] = mk(mk_s(0, 0, 0, 1, 32'h5000, 0, 0, 0),                       0, 0, 32'h0,    0, 0, 0);
    tbl[17] = mk(mk_s(0, 0, 0, 0, 0, 0, 0, 0),                              1, 0, 32'h5000, 0, 0, 0);
    tbl[18] = mk(mk_s(1, 0, 32'h600, 0, 0, 0, 0, 0),                        1, 0, 32'h5000, 0, 0, 0);
    tbl[19] = mk(mk_s(1, 0, 32'h600, 0, 0, 0, 0, 0),                        1, 0, 32'h5000, 0, 0, 0);
    tbl[20] = mk(mk_s(1, 0, 32'h600, 0, 0, 1, 0, 0),                        1, 0, 32'h5000, 0, 0, 0);
    tbl[21] = mk(mk_s(1, 0, 32'h600, 0, 0, 1, 0, 0),                        1, 0, 32'h600,  1, 0, 0);
    tbl[22] = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hD0),                         0, 0, 32'h0,    0, 0, 1);
    tbl[23] = mk(mk_s(0, 4'hF, 32'h700, 0, 0, 1, 1, 32'hD1),                0, 4'hF, 32'h700, 1, 1, 0);
    tbl[24] = mk(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hD2),                         0, 0, 32'h0,    0, 1, 0);
    tbl[25] = mk(mk_s(0, 0, 0, 0, 0, 1, 0, 0),                              0, 0, 32'h0,    0, 0, 0);

    rst_i = 1'b1;
    drive(mk_s(0, 0, 0, 0, 0, 0, 0, 32'hA5A50000));
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_mem_rd", 32'(mem_rd_o), 32'h0);
    check("rst_mem_wr", 32'(mem_wr_o), 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_core_accept", 32'(core_accept_o), 32'h0);
    check("rst_acks", 32'({core_ack_o, conv_ack_o}), 32'h0);
    check("rst_flags", 32'({conv_ovf_o, ack_err_o}), 32'h0);
    check("rst_rdata_mirror", core_data_rd_o, 32'hA5A50000);
    rst_i = 1'b0;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].s);
      check($sformatf("vec%0d_mem_rd", i), 32'(mem_rd_o), 32'(tbl[i].e_rd));
      check($sformatf("vec%0d_mem_wr", i), 32'(mem_wr_o), 32'(tbl[i].e_wr));
      check($sformatf("vec%0d_mem_addr", i), mem_addr_o, tbl[i].e_addr);
      check($sformatf("vec%0d_core_accept", i), 32'(core_accept_o), 32'(tbl[i].e_cacc));
      check($sformatf("vec%0d_core_ack", i), 32'(core_ack_o), 32'(tbl[i].e_cack));
      check($sformatf("vec%0d_conv_ack", i), 32'(conv_ack_o), 32'(tbl[i].e_vack));
      tick();
    end
    check("tbl_no_ovf", 32'(conv_ovf_o), 32'h0);

    // Five conv pulses into a stalled memory: the fifth is dropped.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(mk_s(0, 0, 0, 1, 32'h7000 + 32'(4 * k), 0, 0, 0));
      if (k == 4) check("ovf_before_drop", 32'(conv_ovf_o), 32'h0);
      tick();
    end
    step(mk_s(0, 0, 0, 0, 0, 0, 0, 0));
    check("ovf_set", 32'(conv_ovf_o), 32'h1);
    check("ovf_hold_addr", mem_addr_o, 32'h7000);
    tick();
    for (int k = 0; k < 8; k++) begin
      step(mk_s(0, 0, 0, 0, 0, 1, mq_route.size() > 0, 32'hE000 + 32'(k)));
      tick();
    end
    check("ovf_sticky", 32'(conv_ovf_o), 32'h1);

    // Route FIFO full: the fifth core read waits for an ack, then issues the cycle after.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(mk_s(1, 0, 32'h800 + 32'(4 * k), 0, 0, 1, 0, 0));
      tick();
    end
    step(mk_s(1, 0, 32'h810, 0, 0, 1, 0, 0));
    check("maxout_blocked_rd", 32'(mem_rd_o), 32'h0);
    check("maxout_blocked_acc", 32'(core_accept_o), 32'h0);
    tick();
    step(mk_s(1, 0, 32'h810, 0, 0, 1, 1, 32'hF0));
    check("maxout_ack_cycle_rd", 32'(mem_rd_o), 32'h0);
    check("maxout_ack_cycle_cack", 32'(core_ack_o), 32'h1);
    tick();
    step(mk_s(1, 0, 32'h810, 0, 0, 1, 0, 0));
    check("maxout_issue_rd", 32'(mem_rd_o), 32'h1);
    check("maxout_issue_addr", mem_addr_o, 32'h810);
    check("maxout_issue_acc", 32'(core_accept_o), 32'h1);
    tick();
    for (int k = 0; k < 4; k++) begin
      step(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hF1));
      tick();
    end

    // Reset with two transactions outstanding: their acks become errors.
    do_reset();
    step(mk_s(1, 0, 32'h900, 0, 0, 1, 0, 0)); tick();
    step(mk_s(1, 0, 32'h904, 0, 0, 1, 0, 0)); tick();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      step(mk_s(0, 0, 0, 0, 0, 1, 1, 32'hBAD0));
      check("stale_ack_core", 32'(core_ack_o), 32'h0);
      check("stale_ack_conv", 32'(conv_ack_o), 32'h0);
      tick();
    end
    step(mk_s(0, 0, 0, 0, 0, 1, 0, 0));
    check("stale_ack_err", 32'(ack_err_o), 32'h1);
    tick();

    // Randomized traffic; the core holds each request until the model sees it accepted.
    do_reset();
    begin
      bit          busy;
      logic        c_rd;
      logic [3:0]  c_wr;
      logic [31:0] c_addr;
      logic        ack;
      busy = 1'b0; c_rd = 1'b0; c_wr = 4'b0; c_addr = 32'b0;
      for (int n = 0; n < 800; n++) begin
        if (!busy && $urandom_range(0, 2) == 0) begin
          busy = 1'b1;
          if ($urandom_range(0, 1) == 1) begin
            c_rd = 1'b1; c_wr = 4'b0;
          end else begin
            c_rd = 1'b0; c_wr = 4'($urandom_range(1, 15));
          end
          c_addr = $urandom & 32'hFFFF_FFFC;
        end
        ack = (mq_route.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
        step(mk_s(busy ? c_rd : 1'b0, busy ? c_wr : 4'b0, busy ? c_addr : 32'b0,
                  $urandom_range(0, 2) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, ack, $urandom));
        if (p_acc && p_src == 0) busy = 1'b0;
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_mem_arbiter.md
# conv_mem_arbiter

Shares the single data-memory port between the core LSU and the convolution accelerator's load engine. It buffers accelerator read requests, which arrive without backpressure, in a small FIFO. It arbitrates round-robin between core and accelerator, holds a granted request stable until memory accepts it, and routes in-order responses back to their owner through a tracking FIFO. It sits between the core/accelerator and the data memory or D-cache request port.

## Interface
Parameters:
- CONV_FIFO_DEPTH, 4, accelerator request buffer entries (power of 2, ≥2)
- MAX_OUTSTANDING, 4, accepted-but-unacknowledged memory transactions (power of 2, ≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- core_rd_i  in  1  core read request, held until core_accept_o
- core_wr_i  in  4  core write byte enables, held until core_accept_o
- core_addr_i  in  32  core address
- core_data_wr_i  in  32  core write data
- core_accept_o  out  1  core request taken this cycle
- core_ack_o  out  1  core response
- core_data_rd_o  out  32  core read data
- conv_rd_i  in  1  accelerator read pulse, never stalled
- conv_addr_i  in  32  accelerator address
- conv_ack_o  out  1  accelerator response
- conv_data_o  out  32  accelerator read data
- mem_rd_o  out  1  memory read request
- mem_wr_o  out  4  memory write byte enables
- mem_addr_o  out  32  memory address
- mem_data_wr_o  out  32  memory write data
- mem_accept_i  in  1  memory took request
- mem_ack_i  in  1  memory response, in issue order
- mem_data_rd_i  in  32  memory read data
- conv_ovf_o  out  1  sticky: accelerator request dropped, FIFO full
- ack_err_o  out  1  sticky: mem_ack_i with no outstanding transaction

## Operation
- Conv FIFO: conv_rd_i pushes conv_addr_i. If the FIFO is full and no pop occurs that cycle, the request is dropped and conv_ovf_o sets. A push and pop in the same cycle on a full FIFO is legal and does not drop.
- Pending sources: core_pend = core_rd_i | (|core_wr_i); conv_pend = conv FIFO not empty.
- Grant FSM states: IDLE, HOLD_CORE, HOLD_CONV.
  - IDLE: if issue is permitted and exactly one source is pending, that source is chosen. If both are pending, the source not served last is chosen (last_q, reset = conv, so core wins the first tie). The chosen request drives mem_* combinationally.
    - mem_accept_i same cycle: the grant completes, last_q updates, the FSM stays in IDLE.
    - Otherwise: go to HOLD_CORE or HOLD_CONV.
  - HOLD_x: keep driving the same source's request unchanged, with no re-arbitration. On mem_accept_i: return to IDLE and update last_q.
- Issue permitted only when the route FIFO is not full. A full route FIFO blocks only new grants from IDLE; a request already in HOLD_x stays held. When issue is not permitted, mem_rd_o=0 and mem_wr_o=0.
- Accept outputs:
  - core_accept_o = mem_accept_i while core is granted.
  - The conv FIFO pops on mem_accept_i while conv is granted.
- Route FIFO: each accepted transaction pushes its owner bit (0 = core, 1 = conv), reads and writes alike. mem_ack_i pops the FIFO and steers ack/data to the owner. A core write ack raises core_ack_o.
  - Push and pop in the same cycle are allowed.
  - mem_ack_i with the route FIFO empty: ack_err_o sets and no ack is forwarded.
- Conv writes do not exist. The conv request always drives mem_wr_o=0 and mem_data_wr_o=0.
- Reset clears both FIFOs, returns the FSM to IDLE, sets last_q=conv and clears both sticky flags. Acks for transactions issued before reset fall into the ack_err_o case.

## Timing
- Reset values: all outputs 0 except the combinational pass-through data. core_data_rd_o and conv_data_o mirror mem_data_rd_i unconditionally.
- Core path is combinational: a core request with IDLE and a core win appears on mem_* the same cycle. Best case, core_accept_o is asserted in the request cycle.
- Conv path:
  - conv_rd_i at cycle N is eligible for issue at N+1 at the earliest.
  - Minimum accelerator round trip with zero-latency memory ack: issue at N+1, ack at N+2.
- core_ack_o and conv_ack_o are combinational from mem_ack_i, in the same cycle.
- Under continuous contention with immediate accept, grants strictly alternate core/conv, one per cycle.
- Throughput: one accepted transaction per cycle when memory accepts every cycle and the route FIFO is not full.

## Test plan
- Core only, mem_accept_i tied high, ack one cycle later: read 0x100 returns 0xDEADBEEF; core_accept_o in the request cycle, core_ack_o the next cycle, conv_ack_o never asserted.
- Conv burst of 4 pulses (0x2000..0x200C) with the core idle: 4 mem reads in order, starting the cycle after the first pulse; 4 conv_ack_o with data matched in order; conv_ovf_o stays 0.
- Core and conv both pending continuously, accept always high: mem issue order core, conv, core, conv…; the ack routing sequence matches.
- mem_accept_i held low 3 cycles during a conv grant while the core asserts a request: mem_addr_o stays on the conv address for all 3 cycles; the core is granted the cycle after the conv accept.
- Remaining boundary cases:
  - 5 conv pulses with memory stalled: the 5th is dropped and conv_ovf_o=1.
  - With MAX_OUTSTANDING=4 and no acks: the 5th request is not issued until one ack arrives.
  - Reset with 2 outstanding: the subsequent acks set ack_err_o and produce no core_ack_o or conv_ack_o.
